// File: rtl/disp_pkg.sv
// Shared definitions for the multiplexed 7-segment display path:
// scan FSM encoding, blank/off codes and the digit-select helper.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_BLANK = 2'd2,
        ST_DRIVE = 2'd3
    } scan_state_t;

    localparam int                    MAX_DIGITS = 4;
    localparam logic [3:0]            BLANK_CODE = 4'hF;
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF  = '1;

    // Pick BCD digit idx (0 = units) out of a packed MAX_DIGITS-wide word.
    function automatic logic [3:0] digit_sel(input logic [4*MAX_DIGITS-1:0] bcd,
                                             input logic [1:0]              idx);
        return bcd[4*idx +: 4];
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Interval timer shared by the blank and dwell phases: counts 0..limit-1,
// holds at the terminal count and restarts from 0 whenever clear is high.
module scan_timer #(
    parameter int TMR_W = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [TMR_W-1:0] limit,
    output logic             done
);

    logic [TMR_W-1:0] count;

    assign done = (count == limit - 1'b1);

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (!done) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/display_scan_sched.sv
// Digit scan scheduler: blanks, then drives each digit in turn from a display
// register that is refreshed from a one-deep pending slot only at frame start.
module display_scan_sched
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 3,
    parameter int DWELL_CYCLES = 65536,
    parameter int BLANK_CYCLES = 256,
    parameter int TMR_W        = 17
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    lz_en,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    bcd_valid,
    output logic                    bcd_ready,
    output logic [3:0]              nibble_out,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic                    frame_start
);

    localparam int IDX_W = 2;

    scan_state_t             state, next_state;
    logic [IDX_W-1:0]        idx;
    logic                    last_digit;
    logic                    tmr_clear, tmr_done;
    logic [TMR_W-1:0]        tmr_limit;
    logic [4*NUM_DIGITS-1:0] disp_q, pend_q;
    logic                    pend_full;
    logic [4*MAX_DIGITS-1:0] disp_pad;
    logic [MAX_DIGITS-1:0]   lz_mask;
    logic [NUM_DIGITS-1:0]   anode_d;
    logic [3:0]              nibble_d;
    logic                    frame_start_d;

    assign last_digit = (idx == IDX_W'(NUM_DIGITS - 1));
    assign bcd_ready  = !pend_full;
    assign disp_pad   = (4*MAX_DIGITS)'(disp_q);
    assign tmr_clear  = !enable || (next_state != state);
    assign tmr_limit  = (state == ST_DRIVE) ? TMR_W'(DWELL_CYCLES) : TMR_W'(BLANK_CYCLES);

    scan_timer #(.TMR_W(TMR_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (tmr_clear),
        .limit (tmr_limit),
        .done  (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        if (!enable) begin
            next_state = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:  next_state = ST_LOAD;
                ST_LOAD:  next_state = ST_BLANK;
                ST_BLANK: if (tmr_done) next_state = ST_DRIVE;
                ST_DRIVE: if (tmr_done) next_state = last_digit ? ST_LOAD : ST_BLANK;
                default:  next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (!enable || state == ST_LOAD) begin
            idx <= '0;
        end else if (state == ST_DRIVE && tmr_done && !last_digit) begin
            idx <= idx + 1'b1;
        end
    end

    // NOTE: display and pending are real registers with defined reset contents, so they
    // are reset like any other state rather than left to power-up values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q    <= '0;
            pend_q    <= '0;
            pend_full <= 1'b0;
        end else begin
            if (state == ST_LOAD && pend_full) begin
                disp_q    <= pend_q;
                pend_full <= 1'b0;
            end
            // Accepting only when empty means a drain and a capture never coincide.
            if (bcd_valid && !pend_full) begin
                pend_q    <= bcd_in;
                pend_full <= 1'b1;
            end
        end
    end

    // A digit is suppressed when it and everything above it are zero; units never are.
    always_comb begin
        logic run;
        run     = 1'b1;
        lz_mask = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            run        = run && (disp_q[4*k +: 4] == 4'd0);
            lz_mask[k] = run && (k != 0);
        end
    end

    // Outputs follow the next state so they line up with the state they describe;
    // a digit's look is decided on slot entry and held for the whole dwell.
    always_comb begin
        anode_d       = ANODE_OFF[NUM_DIGITS-1:0];
        nibble_d      = BLANK_CODE;
        frame_start_d = (next_state == ST_LOAD);
        if (next_state == ST_DRIVE) begin
            if (state == ST_DRIVE) begin
                anode_d  = anode_n;
                nibble_d = nibble_out;
            end else if (!(lz_en && lz_mask[idx])) begin
                anode_d  = ~(NUM_DIGITS'(1) << idx);
                nibble_d = digit_sel(disp_pad, idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_n     <= ANODE_OFF[NUM_DIGITS-1:0];
            nibble_out  <= BLANK_CODE;
            frame_start <= 1'b0;
        end else begin
            anode_n     <= anode_d;
            nibble_out  <= nibble_d;
            frame_start <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_display_scan_sched.sv
// Self-checking bench for display_scan_sched: directed scenarios plus random
// values, compared every cycle against a frame-position reference model.
module tb_display_scan_sched;

    localparam int ND    = 3;
    localparam int DW    = 4;
    localparam int BL    = 2;
    localparam int SLOT  = BL + DW;
    localparam int FRAME = ND * SLOT + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          lz_en;
    logic [4*ND-1:0] bcd_in;
    logic          bcd_valid;
    logic          bcd_ready;
    logic [3:0]    nibble_out;
    logic [ND-1:0] anode_n;
    logic          frame_start;

    display_scan_sched #(
        .NUM_DIGITS   (ND),
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (BL),
        .TMR_W        (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .lz_en       (lz_en),
        .bcd_in      (bcd_in),
        .bcd_valid   (bcd_valid),
        .bcd_ready   (bcd_ready),
        .nibble_out  (nibble_out),
        .anode_n     (anode_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: m_t is the position within the frame (0 = LOAD cycle, -1 = dark).
    int          m_t;
    logic [11:0] m_disp, m_pend;
    bit          m_pend_v, m_xfer;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t      = -1;
        m_disp   = '0;
        m_pend   = '0;
        m_pend_v = 1'b0;
        m_xfer   = 1'b0;
    endtask

    task automatic model_edge();
        bit pv;
        pv     = m_pend_v;
        m_xfer = bcd_valid && !pv;
        if (m_t == 0 && pv) begin
            m_disp   = m_pend;
            m_pend_v = 1'b0;
        end
        if (m_xfer) begin
            m_pend   = bcd_in;
            m_pend_v = 1'b1;
        end
        if (!enable)      m_t = -1;
        else if (m_t < 0) m_t = 0;
        else              m_t = (m_t + 1) % FRAME;
    endtask

    task automatic check_outputs();
        logic [ND-1:0] exp_an;
        logic [3:0]    exp_nib;
        int            k, slot;
        exp_an  = '1;
        exp_nib = 4'hF;
        if (m_t > 0) begin
            k    = m_t - 1;
            slot = k / SLOT;
            if ((k % SLOT) >= BL &&
                !(lz_en && slot > 0 && (m_disp >> (4*slot)) == 12'd0)) begin
                exp_an  = ~(ND'(1) << slot);
                exp_nib = 4'((m_disp >> (4*slot)) & 12'hF);
            end
        end
        check("anode_n",     16'(anode_n),     16'(exp_an));
        check("nibble_out",  16'(nibble_out),  16'(exp_nib));
        check("frame_start", 16'(frame_start), 16'(m_t == 0));
        check("bcd_ready",   16'(bcd_ready),   16'(!m_pend_v));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_outputs();
        end
    endtask

    // Hold an offer until the model sees it accepted; bounded by a few frames.
    task automatic offer(input logic [11:0] v);
        bcd_in    = v;
        bcd_valid = 1'b1;
        for (int i = 0; i < 4 * FRAME; i++) begin
            step(1);
            if (m_xfer) break;
        end
        bcd_valid = 1'b0;
    endtask

    task automatic wait_t(input int target);
        for (int i = 0; i < 2 * FRAME && m_t != target; i++) step(1);
    endtask

    initial begin
        logic [11:0] v;
        rst_n     = 1'b0;
        enable    = 1'b0;
        lz_en     = 1'b0;
        bcd_valid = 1'b0;
        bcd_in    = '0;
        model_reset();

        // Reset values, then free-running scan with an all-zero display.
        #12;
        check_outputs();
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;
        step(2 * FRAME);

        // Mid-frame offer shows only from the next frame.
        wait_t(5);
        offer(12'h127);
        step(2 * FRAME);

        // Back-to-back offers: second stalls until LOAD drains the first.
        wait_t(3);
        offer(12'h045);
        offer(12'h046);
        step(3 * FRAME);

        // Leading-zero suppression.
        wait_t(0);
        lz_en = 1'b1;
        offer(12'h005);
        step(2 * FRAME);
        offer(12'h000);
        step(2 * FRAME);

        // Random values (zero-biased digits, some non-BCD) with random suppression.
        for (int n = 0; n < 8; n++) begin
            for (int d = 0; d < ND; d++)
                v[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            wait_t(0);
            lz_en = 1'($urandom_range(0, 1));
            offer(v);
            step($urandom_range(FRAME, 2 * FRAME));
        end

        // Enable dropped in the tens DRIVE slot, offer while dark, then restart.
        wait_t(0);
        lz_en = 1'b0;
        offer(12'h389);
        step(FRAME);
        wait_t(10);
        enable = 1'b0;
        step(3);
        offer(12'h512);
        step(2);
        enable = 1'b1;
        step(2 * FRAME);

        // Asynchronous reset mid-DRIVE with the pending slot full.
        wait_t(1);
        offer(12'h777);
        wait_t(4);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        step(2 * FRAME);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
